// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU ops, op classes, fetched-instruction view and decoded record.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } AluOp;

    typedef enum logic [3:0] {
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
        CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_MISC_MEM, CLS_SYSTEM, CLS_ILLEGAL
    } OpClass;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } RType;

    typedef union packed {
        logic [31:0] inst32;
        RType        r;
    } Instruction;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        AluOp        alu_op;
        OpClass      cls;
        logic [2:0]  funct3;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_system;
        logic        illegal;
    } DecodedInst;

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic AluOp alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode bus (no backpressure, carries flush) and decode->issue valid/ready bus.
interface dec_in_if;
    import decode_pkg::*;
    logic        flush;
    logic        inst_valid;
    Instruction  inst;
    logic [31:0] inst_pc;

    modport master (output flush, inst_valid, inst, inst_pc);
    modport slave  (input  flush, inst_valid, inst, inst_pc);
endinterface

interface dec_out_if;
    import decode_pkg::*;
    logic       out_valid;
    logic       out_ready;
    DecodedInst dec_out;

    modport master (output out_valid, dec_out, input  out_ready);
    modport slave  (input  out_valid, dec_out, output out_ready);
endinterface

// File: rtl/decode_stage_inst_decoder.sv
// Combinational RV32I decoder: Instruction + pc -> DecodedInst, zero latency.
module inst_decoder
    import decode_pkg::*;
(
    input  Instruction  inst_i,
    input  logic [31:0] pc_i,
    output DecodedInst  dec_o
);

    logic [31:0] w;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        writes_rd;
    logic        ill;

    assign w     = inst_i.inst32;
    assign opc   = inst_i.r.opcode;
    assign f3    = inst_i.r.funct3;
    assign f7    = inst_i.r.funct7;
    assign imm_i = {{20{w[31]}}, w[31:20]};
    assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u = {w[31:12], 12'b0};
    assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    always_comb begin
        dec_o        = '0;
        dec_o.pc     = pc_i;
        dec_o.rd     = inst_i.r.rd;
        dec_o.funct3 = f3;
        dec_o.alu_op = ALU_ADD;
        dec_o.cls    = CLS_ILLEGAL;
        writes_rd    = 1'b0;
        ill          = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_o.cls = CLS_LUI; dec_o.imm = imm_u; dec_o.alu_src_imm = 1'b1; writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.cls = CLS_AUIPC; dec_o.imm = imm_u; dec_o.alu_src_imm = 1'b1; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec_o.cls = CLS_JAL; dec_o.imm = imm_j; writes_rd = 1'b1;
            end
            OPC_JALR: begin
                dec_o.cls = CLS_JALR; dec_o.rs1 = inst_i.r.rs1; dec_o.imm = imm_i;
                dec_o.alu_src_imm = 1'b1; writes_rd = 1'b1;
                ill = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_o.cls = CLS_BRANCH; dec_o.rs1 = inst_i.r.rs1; dec_o.rs2 = inst_i.r.rs2;
                dec_o.imm = imm_b; dec_o.alu_op = ALU_SUB;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                dec_o.cls = CLS_LOAD; dec_o.rs1 = inst_i.r.rs1; dec_o.imm = imm_i;
                dec_o.alu_src_imm = 1'b1; dec_o.mem_read = 1'b1; writes_rd = 1'b1;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                dec_o.cls = CLS_STORE; dec_o.rs1 = inst_i.r.rs1; dec_o.rs2 = inst_i.r.rs2;
                dec_o.imm = imm_s; dec_o.alu_src_imm = 1'b1; dec_o.mem_write = 1'b1;
                ill = (f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                dec_o.cls = CLS_OP_IMM; dec_o.rs1 = inst_i.r.rs1; dec_o.imm = imm_i;
                dec_o.alu_src_imm = 1'b1; writes_rd = 1'b1;
                dec_o.alu_op = alu_from_f3(f3, (f3 == 3'd5) & w[30]);
                // Shift-immediates reuse imm[11:5] as a funct7 that must be canonical
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
            end
            OPC_OP: begin
                dec_o.cls = CLS_OP; dec_o.rs1 = inst_i.r.rs1; dec_o.rs2 = inst_i.r.rs2; writes_rd = 1'b1;
                if (f7 == 7'h00)
                    dec_o.alu_op = alu_from_f3(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                    dec_o.alu_op = alu_from_f3(f3, 1'b1);
                else
                    ill = 1'b1;
            end
            OPC_MISC_MEM: dec_o.cls = CLS_MISC_MEM;
            OPC_SYSTEM: begin
                dec_o.cls = CLS_SYSTEM; dec_o.is_system = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        dec_o.illegal   = ill;
        dec_o.reg_write = writes_rd & (inst_i.r.rd != 5'd0) & ~ill;
        if (ill) begin
            dec_o.mem_read  = 1'b0;
            dec_o.mem_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction queue absorbing fetch, registered decode output; 2-cycle push-to-valid latency.
// Fetch cannot be stalled, so a push into a full queue with no pop is dropped and flagged in sticky overflow.
module decode_stage
    import decode_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    dec_in_if.slave                      in_if,
    dec_out_if.master                    out_if,
    output logic [$clog2(QUEUE_DEPTH):0] q_count,
    output logic                         overflow
);

    localparam int              PW       = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(QUEUE_DEPTH);

    typedef struct packed {
        Instruction  inst;
        logic [31:0] pc;
    } qent_t;

    qent_t          mem_q [QUEUE_DEPTH];
    qent_t          head;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]    cnt_q, cnt_d;
    logic           out_vld_q, out_vld_d;
    DecodedInst     out_q, out_d, head_dec;
    logic           ovf_q, ovf_d;
    logic           head_vld, full, push, pop, push_ok;

    assign head = mem_q[rd_ptr_q];

    inst_decoder u_dec (
        .inst_i (head.inst),
        .pc_i   (head.pc),
        .dec_o  (head_dec)
    );

    always_comb begin
        head_vld  = (cnt_q != '0);
        full      = (cnt_q == FULL_CNT);
        push      = in_if.inst_valid & ~in_if.flush;
        pop       = head_vld & (~out_vld_q | out_if.out_ready);
        // A pop frees the head slot this edge, so a full queue can still accept
        push_ok   = push & (~full | pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        if (in_if.flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (pop) begin
                out_vld_d = 1'b1;
                out_d     = head_dec;
            end else if (out_if.out_ready) begin
                out_vld_d = 1'b0;
            end
            if (push & full & ~pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= '{inst: in_if.inst, pc: in_if.inst_pc};
    end

    assign out_if.out_valid = out_vld_q;
    assign out_if.dec_out   = out_q;
    assign q_count          = cnt_q;
    assign overflow         = ovf_q;

    queue_drop_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $warning("decode_stage: queue full, fetched instruction dropped");

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: streaming, stall/overflow, flush, decode goldens, reset.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q_count;
    logic       overflow;
    exp_t       sb [$];
    bit         sb_en = 1'b0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    dec_in_if  fetch_bus ();
    dec_out_if issue_bus ();

    decode_stage #(.QUEUE_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (fetch_bus),
        .out_if   (issue_bus),
        .q_count  (q_count),
        .overflow (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // addi rd, x0, imm; the expected record is derived from the operands, not from the DUT
    task automatic drive_addi(input logic [4:0] rd, input logic [11:0] imm, input logic [31:0] pc,
                              input bit expect_out);
        exp_t e;
        fetch_bus.inst_valid = 1'b1;
        fetch_bus.inst       = {imm, 5'd0, 3'd0, rd, 7'h13};
        fetch_bus.inst_pc    = pc;
        if (expect_out) begin
            e.pc  = pc;
            e.rd  = rd;
            e.imm = {{20{imm[11]}}, imm};
            e.rw  = (rd != 5'd0);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && !rst && !fetch_bus.flush && issue_bus.out_valid && issue_bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got pc=%h, required no record", issue_bus.dec_out.pc);
                end else begin
                    e = sb.pop_front();
                    if (issue_bus.dec_out.pc !== e.pc || issue_bus.dec_out.rd !== e.rd ||
                        issue_bus.dec_out.imm !== e.imm || issue_bus.dec_out.reg_write !== e.rw) begin
                        errors++;
                        $display("FAIL sb_record got pc=%h rd=%0d imm=%h rw=%b, required pc=%h rd=%0d imm=%h rw=%b",
                                 issue_bus.dec_out.pc, issue_bus.dec_out.rd, issue_bus.dec_out.imm,
                                 issue_bus.dec_out.reg_write, e.pc, e.rd, e.imm, e.rw);
                    end
                end
            end
        end
    endtask

    task automatic decode_one(input logic [31:0] w, output DecodedInst d);
        issue_bus.out_ready  = 1'b1;
        fetch_bus.inst_valid = 1'b1;
        fetch_bus.inst       = w;
        fetch_bus.inst_pc    = 32'h200;
        step();
        fetch_bus.inst_valid = 1'b0;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (issue_bus.out_valid) begin
                d = issue_bus.dec_out;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL decode_timeout inst=%h got out_valid=0, required out_valid=1", w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d required 0", q_count); end
        checks++; if (issue_bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", issue_bus.out_valid); end
        checks++; if (issue_bus.dec_out !== '0) begin errors++; $display("FAIL reset_dec_out got %h required 0", issue_bus.dec_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [11:0] imms [4] = '{12'h7FF, 12'h800, 12'h001, 12'hFFE};
        logic        exp_vld;
        sb_en = 1'b1;
        issue_bus.out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s < 4) drive_addi(5'(s + 1), imms[s], 32'(4 * s), 1'b1);
            else       fetch_bus.inst_valid = 1'b0;
            step();
            exp_vld = (s >= 1 && s <= 4);
            checks++;
            if (issue_bus.out_valid !== exp_vld) begin
                errors++;
                $display("FAIL stream_valid cycle=%0d got %b required %b", s, issue_bus.out_valid, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if (issue_bus.dec_out.pc !== 32'(4 * (s - 1))) begin
                    errors++;
                    $display("FAIL stream_order cycle=%0d got pc=%h required %h", s, issue_bus.dec_out.pc, 32'(4 * (s - 1)));
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain got %0d pending required 0", sb.size()); end
        sb_en = 1'b0;
    endtask

    task automatic test_decode_golden();
        DecodedInst d;
        decode_one(32'hFFF00093, d);
        checks++; if (d.imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h required ffffffff", d.imm); end
        checks++; if (d.rd !== 5'd1 || d.reg_write !== 1'b1) begin errors++; $display("FAIL addi_rd got rd=%0d rw=%b required rd=1 rw=1", d.rd, d.reg_write); end
        checks++; if (d.alu_op !== ALU_ADD || d.alu_src_imm !== 1'b1 || d.illegal !== 1'b0) begin
            errors++; $display("FAIL addi_alu got op=%0d src_imm=%b ill=%b required op=%0d src_imm=1 ill=0", d.alu_op, d.alu_src_imm, d.illegal, ALU_ADD); end
        checks++; if (d.pc !== 32'h200) begin errors++; $display("FAIL addi_pc got %h required 00000200", d.pc); end
        decode_one(32'hFE000EE3, d);
        checks++; if (d.imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h required fffffffc", d.imm); end
        checks++; if (d.reg_write !== 1'b0 || d.cls !== CLS_BRANCH) begin
            errors++; $display("FAIL beq_cls got rw=%b cls=%0d required rw=0 cls=%0d", d.reg_write, d.cls, CLS_BRANCH); end
    endtask

    task automatic test_illegal_edge();
        DecodedInst d;
        decode_one(32'h00000000, d);
        checks++; if (d.illegal !== 1'b1 || d.reg_write !== 1'b0) begin errors++; $display("FAIL zero_inst got ill=%b rw=%b required ill=1 rw=0", d.illegal, d.reg_write); end
        decode_one(32'h00000013, d);
        checks++; if (d.illegal !== 1'b0 || d.reg_write !== 1'b0) begin errors++; $display("FAIL addi_x0 got ill=%b rw=%b required ill=0 rw=0", d.illegal, d.reg_write); end
        decode_one(32'h40000033, d);
        checks++; if (d.alu_op !== ALU_SUB || d.illegal !== 1'b0) begin errors++; $display("FAIL sub got op=%0d ill=%b required op=%0d ill=0", d.alu_op, d.illegal, ALU_SUB); end
        decode_one(32'h40001033, d);
        checks++; if (d.illegal !== 1'b1) begin errors++; $display("FAIL op_f7_f3 got ill=%b required 1", d.illegal); end
        decode_one(32'h00100073, d);
        checks++; if (d.is_system !== 1'b1 || d.illegal !== 1'b0) begin errors++; $display("FAIL ebreak got sys=%b ill=%b required sys=1 ill=0", d.is_system, d.illegal); end
        decode_one(32'h00003003, d);
        checks++; if (d.illegal !== 1'b1 || d.mem_read !== 1'b0) begin errors++; $display("FAIL load_f3 got ill=%b mrd=%b required ill=1 mrd=0", d.illegal, d.mem_read); end
        decode_one(32'h4010D093, d);
        checks++; if (d.alu_op !== ALU_SRA || d.illegal !== 1'b0) begin errors++; $display("FAIL srai got op=%0d ill=%b required op=%0d ill=0", d.alu_op, d.illegal, ALU_SRA); end
        decode_one(32'h40109093, d);
        checks++; if (d.illegal !== 1'b1) begin errors++; $display("FAIL slli_f7 got ill=%b required 1", d.illegal); end
        step();
    endtask

    task automatic test_stall_overflow();
        bit drained = 1'b0;
        sb_en = 1'b1;
        issue_bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_addi(5'(i + 1), 12'(i + 10), 32'(4 * i), 1'b1);
            step();
        end
        checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL stall_q_count got %0d required 3", q_count); end
        checks++; if (issue_bus.out_valid !== 1'b1 || issue_bus.dec_out.pc !== 32'h0) begin
            errors++; $display("FAIL stall_hold got vld=%b pc=%h required vld=1 pc=0", issue_bus.out_valid, issue_bus.dec_out.pc); end
        drive_addi(5'd5, 12'd20, 32'h10, 1'b1);
        step();
        checks++; if (q_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL stall_fill got cnt=%0d ovf=%b required cnt=4 ovf=0", q_count, overflow); end
        drive_addi(5'd6, 12'd21, 32'h14, 1'b0);
        step();
        checks++; if (overflow !== 1'b1 || q_count !== 3'd4) begin errors++; $display("FAIL overflow got ovf=%b cnt=%0d required ovf=1 cnt=4", overflow, q_count); end
        checks++; if (issue_bus.dec_out.pc !== 32'h0) begin errors++; $display("FAIL stall_stable got pc=%h required 0", issue_bus.dec_out.pc); end
        fetch_bus.inst_valid = 1'b0;
        issue_bus.out_ready  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (sb.size() == 0) begin drained = 1'b1; break; end
        end
        checks++; if (!drained) begin errors++; $display("FAIL stall_drain got %0d pending required 0", sb.size()); end
        step();
        checks++; if (issue_bus.out_valid !== 1'b0 || q_count !== 3'd0) begin
            errors++; $display("FAIL stall_empty got vld=%b cnt=%0d required vld=0 cnt=0", issue_bus.out_valid, q_count); end
        sb_en = 1'b0;
    endtask

    task automatic test_flush();
        sb_en = 1'b1;
        issue_bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_addi(5'(i + 7), 12'(i), 32'(32'h20 + 4 * i), 1'b1);
            step();
        end
        checks++; if (q_count !== 3'd2 || issue_bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL preflush got cnt=%0d vld=%b required cnt=2 vld=1", q_count, issue_bus.out_valid); end
        sb.delete();
        drive_addi(5'd3, 12'd3, 32'h40, 1'b0);
        fetch_bus.flush     = 1'b1;
        issue_bus.out_ready = 1'b1;
        step();
        fetch_bus.flush = 1'b0;
        checks++; if (q_count !== 3'd0 || issue_bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush got cnt=%0d vld=%b required cnt=0 vld=0", q_count, issue_bus.out_valid); end
        drive_addi(5'd4, 12'h123, 32'h100, 1'b1);
        step();
        fetch_bus.inst_valid = 1'b0;
        checks++; if (issue_bus.out_valid !== 1'b0) begin errors++; $display("FAIL postflush_early got vld=%b required 0", issue_bus.out_valid); end
        step();
        checks++; if (issue_bus.out_valid !== 1'b1 || issue_bus.dec_out.pc !== 32'h100) begin
            errors++; $display("FAIL postflush got vld=%b pc=%h required vld=1 pc=00000100", issue_bus.out_valid, issue_bus.dec_out.pc); end
        step();
        checks++; if (issue_bus.out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL postflush_drain got vld=%b pending=%0d required vld=0 pending=0", issue_bus.out_valid, sb.size()); end
        sb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue_bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_addi(5'd9, 12'(i), 32'(32'h300 + 4 * i), 1'b0);
            step();
        end
        fetch_bus.inst_valid = 1'b0;
        checks++; if (q_count !== 3'd2 || issue_bus.out_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL prereset got cnt=%0d vld=%b ovf=%b required cnt=2 vld=1 ovf=1", q_count, issue_bus.out_valid, overflow); end
        rst = 1'b1;
        step();
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL midreset_q_count got %0d required 0", q_count); end
        checks++; if (issue_bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b required 0", issue_bus.out_valid); end
        checks++; if (issue_bus.dec_out !== '0) begin errors++; $display("FAIL midreset_dec_out got %h required 0", issue_bus.dec_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got %b required 0", overflow); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        fetch_bus.flush      = 1'b0;
        fetch_bus.inst_valid = 1'b0;
        fetch_bus.inst       = '0;
        fetch_bus.inst_pc    = '0;
        issue_bus.out_ready  = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_stream();
        test_decode_golden();
        test_illegal_edge();
        test_stall_overflow();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
